gf128_inverse: RTL and testbench

GF128_INVERSE -- requirements
Module: gf128_inverse

---
 rtl/gf128_inverse_if.sv | 21 ++
 rtl/gf128_inverse.sv | 109 ++++++++++
 tb/tb_gf128_inverse.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/gf128_inverse_if.sv
// Operand/result handshake bundle for the GF(2^128) inverter.
interface gf128_inverse_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gf128_inverse.sv
// GF(2^128) inverter in GCM bit order: a^-1 = a^(2^128-2) by 127 square/multiply
// pairs sharing one combinational multiplier.
module gf128_inverse #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic            clk,
  input  logic            rst,
  gf128_inverse_if.slave  bus,
  output logic            busy
);

  localparam int unsigned CNT_W = 7;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(127);
  localparam logic [DATA_WIDTH-1:0] ONE      = {1'b1, (DATA_WIDTH-1)'(0)};
  // Reduction constant for x^128+x^7+x^2+x+1 in reflected order.
  localparam logic [DATA_WIDTH-1:0] RED      = {8'hE1, (DATA_WIDTH-8)'(0)};

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] sq_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] mul_a;
  logic [DATA_WIDTH-1:0] mul_res;

  // Shift-and-add GCM multiply; x's MSB is the x^0 coefficient.
  function automatic logic [DATA_WIDTH-1:0] gf_mul(input logic [DATA_WIDTH-1:0] x,
                                                   input logic [DATA_WIDTH-1:0] y);
    logic [DATA_WIDTH-1:0] z;
    logic [DATA_WIDTH-1:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (x[DATA_WIDTH-1-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ RED) : (v >> 1);
    end
    return z;
  endfunction

  // Single multiplier: squares in SQR, accumulates otherwise.
  always_comb begin
    mul_a   = (state_q == SQR) ? sq_q : acc_q;
    mul_res = gf_mul(mul_a, sq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sq_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sq_q       <= bus.in_data;
            acc_q      <= ONE;
            cnt_q      <= CNT_W'(1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SQR;
          end
        end
        SQR: begin
          sq_q    <= mul_res;
          state_q <= MUL;
        end
        MUL: begin
          acc_q <= mul_res;
          if (cnt_q == CNT_LAST) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= mul_res;
            state_q     <= DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= SQR;
          end
        end
        DONE: begin
          // No accept in this cycle: in_ready only rises once back in IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_gf128_inverse.sv
// Directed and random checks of gf128_inverse against an independent
// normal-order carry-less multiply model.
module tb_gf128_inverse;

  localparam logic [127:0] ONE   = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] X_EL  = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] X_INV = 128'hC200_0000_0000_0000_0000_0000_0000_0001;
  localparam int N_RANDOM = 200;
  localparam int TIMEOUT  = 400;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   failures;

  gf128_inverse_if #(.DATA_WIDTH(128)) bus ();

  gf128_inverse #(.DATA_WIDTH(128)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Reverse to normal polynomial order, carry-less multiply, reduce, reverse back.
  function automatic logic [127:0] model_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] an;
    logic [127:0] bn;
    logic [254:0] p;
    an = rev128(a);
    bn = rev128(b);
    p  = '0;
    for (int i = 0; i < 128; i++)
      if (an[i]) p = p ^ (255'(bn) << i);
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        p[i] = 1'b0;
        p    = p ^ (255'(8'h87) << (i - 128));
      end
    end
    return rev128(p[127:0]);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a, scramble in_data after acceptance, wait for the result, stall, consume.
  task automatic do_op(input logic [127:0] a, input int stall,
                       output logic [127:0] res, output int lat);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    while (!bus.in_ready && n < TIMEOUT) begin tick(); n++; end
    if (!bus.in_ready) check("accept_timeout", 128'(0), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = ~a;
    lat = 0;
    while (!bus.out_valid && lat < TIMEOUT) begin
      if (lat == 1) begin
        check("busy_computing", 128'(busy), 128'(1));
        check("in_ready_computing", 128'(bus.in_ready), 128'(0));
        check("out_data_zero_computing", bus.out_data, 128'(0));
      end
      tick();
      lat++;
    end
    if (!bus.out_valid) check("result_timeout", 128'(0), 128'(1));
    res = bus.out_data;
    for (int s = 0; s < stall; s++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== res || bus.in_ready !== 1'b0)
        check("stall_hold", {bus.out_valid, bus.in_ready, bus.out_data[125:0]},
              {1'b1, 1'b0, res[125:0]});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] a;
    int           lat;
    checks   = 0;
    failures = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data", bus.out_data, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    tick();

    do_op(ONE, 0, res, lat);
    check("one_result", res, ONE);
    check("one_latency", 128'(lat), 128'(254));
    check("one_back_idle", 128'(bus.in_ready), 128'(1));

    do_op(X_EL, 0, res, lat);
    check("x_result", res, X_INV);
    check("x_latency", 128'(lat), 128'(254));

    do_op(128'(0), 0, res, lat);
    check("zero_result", res, 128'(0));
    check("zero_latency", 128'(lat), 128'(254));

    // Backpressure: 20 cycles held in DONE, then release and return to IDLE.
    do_op(X_EL, 20, res, lat);
    check("bp_result", res, X_INV);
    check("bp_in_ready_after", 128'(bus.in_ready), 128'(1));
    check("bp_out_valid_after", 128'(bus.out_valid), 128'(0));
    check("bp_out_data_after", bus.out_data, 128'(0));

    // Reset 100 cycles into a computation.
    bus.in_valid = 1'b1;
    bus.in_data  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tick();
    bus.in_valid = 1'b0;
    repeat (100) tick();
    check("mid_busy_before_rst", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    repeat (300) tick();
    check("mid_rst_no_stale", 128'(bus.out_valid), 128'(0));
    a = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    do_op(a, 0, res, lat);
    check("mid_rst_fresh", model_mul(res, a), ONE);
    check("mid_rst_fresh_latency", 128'(lat), 128'(254));

    for (int k = 0; k < N_RANDOM; k++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      if (a == '0) a = ONE;
      do_op(a, int'($urandom_range(0, 3)), res, lat);
      check("rand_inverse", model_mul(res, a), ONE);
      if (lat != 254) check("rand_latency", 128'(lat), 128'(254));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
